// File: rtl/ex_stage_if.sv
// ID/EX/MEM-facing signal bundle of the execute stage.
// ex_stage connects as slave; the driving environment (ID, MEM, SRAM) connects as master.
interface ex_stage_if #(
  parameter int TO_EX_W  = 150,
  parameter int TO_MEM_W = 71,
  parameter int FWD_W    = 38
);
  logic                ID_to_EX_valid;
  logic [TO_EX_W-1:0]  to_EX_data;
  logic                EX_allow_in;
  logic                MEM_allow_in;
  logic                EX_to_MEM_valid;
  logic [TO_MEM_W-1:0] to_MEM_data;
  logic [FWD_W-1:0]    EX_forward;
  logic                data_sram_en;
  logic [3:0]          data_sram_we;
  logic [31:0]         data_sram_addr;
  logic [31:0]         data_sram_wdata;

  modport master (
    output ID_to_EX_valid, to_EX_data, MEM_allow_in,
    input  EX_allow_in, EX_to_MEM_valid, to_MEM_data, EX_forward,
           data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
  );

  modport slave (
    input  ID_to_EX_valid, to_EX_data, MEM_allow_in,
    output EX_allow_in, EX_to_MEM_valid, to_MEM_data, EX_forward,
           data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: latches the ID bundle, runs the one-hot ALU, issues the data SRAM
// request and hands results to MEM plus forwarding/load-use info back to ID.
module ex_stage (
  input  logic       clk,
  input  logic       reset,
  ex_stage_if.slave  bus
);
  logic         ex_valid_reg;
  logic [149:0] bundle_reg;
  logic         ex_ready_go;
  logic         ex_allow_in;

  logic [31:0] pc, rj_value, rkd_value, imm;
  logic [11:0] alu_op;
  logic        src1_is_pc, src2_is_imm, mem_we, res_from_mem, gr_we;
  logic [4:0]  dest;

  logic [31:0] src1, src2, alu_result;
  logic [4:0]  shamt;
  logic [31:0] op_result [12];
  logic [31:0] op_masked [12];

  // Every ALU op completes in one cycle, so EX never holds an instruction on its own.
  assign ex_ready_go = 1'b1;
  assign ex_allow_in = ~ex_valid_reg | (ex_ready_go & bus.MEM_allow_in);

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_reg <= 1'b0;
    end else if (ex_allow_in) begin
      ex_valid_reg <= bus.ID_to_EX_valid;
    end
  end

  // Bundle only changes on an accepted instruction so stalled operands stay stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      bundle_reg <= '0;
    end else if (bus.ID_to_EX_valid && ex_allow_in) begin
      bundle_reg <= bus.to_EX_data;
    end
  end

  assign pc           = bundle_reg[149:118];
  assign rj_value     = bundle_reg[117:86];
  assign rkd_value    = bundle_reg[85:54];
  assign imm          = bundle_reg[53:22];
  assign alu_op       = bundle_reg[21:10];
  assign src1_is_pc   = bundle_reg[9];
  assign src2_is_imm  = bundle_reg[8];
  assign mem_we       = bundle_reg[7];
  assign res_from_mem = bundle_reg[6];
  assign dest         = bundle_reg[5:1];
  assign gr_we        = bundle_reg[0];

  assign src1  = src1_is_pc  ? pc  : rj_value;
  assign src2  = src2_is_imm ? imm : rkd_value;
  assign shamt = src2[4:0];

  assign op_result[0]  = src1 + src2;
  assign op_result[1]  = src1 - src2;
  assign op_result[2]  = {31'd0, $signed(src1) < $signed(src2)};
  assign op_result[3]  = {31'd0, src1 < src2};
  assign op_result[4]  = src1 & src2;
  assign op_result[5]  = ~(src1 | src2);
  assign op_result[6]  = src1 | src2;
  assign op_result[7]  = src1 ^ src2;
  assign op_result[8]  = src1 << shamt;
  assign op_result[9]  = src1 >> shamt;
  assign op_result[10] = $unsigned($signed(src1) >>> shamt);
  assign op_result[11] = src2;

  // One-hot select as AND-OR; an all-zero op vector naturally yields 0.
  genvar gi;
  generate
    for (gi = 0; gi < 12; gi++) begin : g_op_mask
      assign op_masked[gi] = op_result[gi] & {32{alu_op[gi]}};
    end
  endgenerate

  always_comb begin
    alu_result = 32'd0;
    for (int i = 0; i < 12; i++) begin
      alu_result = alu_result | op_masked[i];
    end
  end

  assign bus.EX_allow_in     = ex_allow_in;
  assign bus.EX_to_MEM_valid = ex_valid_reg & ex_ready_go;
  assign bus.to_MEM_data     = {pc, alu_result, res_from_mem, dest, gr_we};

  assign bus.data_sram_en    = ex_valid_reg & (mem_we | res_from_mem);
  assign bus.data_sram_we    = {4{ex_valid_reg & mem_we}};
  assign bus.data_sram_addr  = alu_result;
  assign bus.data_sram_wdata = rkd_value;

  // Fully zero when EX is empty so ID never forwards or stalls on a stale bundle.
  assign bus.EX_forward = {dest & {5{ex_valid_reg & gr_we}},
                           alu_result & {32{ex_valid_reg}},
                           ex_valid_reg & res_from_mem};
endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: behavioural model compared every cycle,
// plus directed vectors with literal expected values.
module tb_ex_stage;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 1'b0;

  always #5 clk = ~clk;

  ex_stage_if bus ();

  ex_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] pc, rj, rkd, imm;
    int          op;
    logic        s1pc, s2imm, mem_we, rfm;
    logic [4:0]  dest;
    logic        gr_we;
  } instr_t;

  instr_t drv;
  instr_t m_instr;
  logic   m_valid;

  function automatic instr_t mk(input logic [31:0] pc, rj, rkd, imm, input int op,
                                input logic s1pc, s2imm, mem_we, rfm,
                                input logic [4:0] dest, input logic gr_we);
    instr_t i;
    i.pc = pc; i.rj = rj; i.rkd = rkd; i.imm = imm; i.op = op;
    i.s1pc = s1pc; i.s2imm = s2imm; i.mem_we = mem_we; i.rfm = rfm;
    i.dest = dest; i.gr_we = gr_we;
    return i;
  endfunction

  function automatic logic [149:0] pack(input instr_t i);
    logic [11:0] oh;
    oh = '0;
    if (i.op >= 0 && i.op < 12) oh[i.op] = 1'b1;
    return {i.pc, i.rj, i.rkd, i.imm, oh, i.s1pc, i.s2imm, i.mem_we, i.rfm, i.dest, i.gr_we};
  endfunction

  // Instruction-level ALU semantics.
  function automatic logic [31:0] model_alu(input instr_t i);
    logic [31:0] a, b;
    a = i.s1pc ? i.pc : i.rj;
    b = i.s2imm ? i.imm : i.rkd;
    case (i.op)
      0:  return a + b;
      1:  return a - b;
      2:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3:  return (a < b) ? 32'd1 : 32'd0;
      4:  return a & b;
      5:  return ~(a | b);
      6:  return a | b;
      7:  return a ^ b;
      8:  return a << b[4:0];
      9:  return a >> b[4:0];
      10: return $unsigned($signed(a) >>> b[4:0]);
      11: return b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always_comb bus.to_EX_data = pack(drv);

  // Model of the stage occupancy
  always @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_instr <= mk(0, 0, 0, 0, -1, 0, 0, 0, 0, 0, 0);
    end else if (!m_valid || bus.MEM_allow_in) begin
      m_valid <= bus.ID_to_EX_valid;
      if (bus.ID_to_EX_valid) m_instr <= drv;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [31:0] r;
      logic [37:0] efwd;
      r = model_alu(m_instr);
      efwd = m_valid ? {(m_instr.gr_we ? m_instr.dest : 5'd0), r, m_instr.rfm} : 38'd0;
      chk("m_allow_in", bus.EX_allow_in, !m_valid || bus.MEM_allow_in);
      chk("m_to_mem_valid", bus.EX_to_MEM_valid, m_valid);
      chk("m_forward", bus.EX_forward, efwd);
      chk("m_sram_en", bus.data_sram_en, m_valid && (m_instr.mem_we || m_instr.rfm));
      chk("m_sram_we", bus.data_sram_we, {4{m_valid && m_instr.mem_we}});
      if (m_valid) begin
        chk("m_to_mem_data", bus.to_MEM_data,
            {m_instr.pc, r, m_instr.rfm, m_instr.dest, m_instr.gr_we});
      end
      if (m_valid && (m_instr.mem_we || m_instr.rfm)) begin
        chk("m_sram_addr", bus.data_sram_addr, r);
        chk("m_sram_wdata", bus.data_sram_wdata, m_instr.rkd);
      end
    end
  end

  task automatic send(input instr_t i);
    drv = i;
    bus.ID_to_EX_valid = 1'b1;
    $display("send pc=%h op=%0d rj=%h rkd=%h imm=%h dest=%0d", i.pc, i.op, i.rj, i.rkd, i.imm, i.dest);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] dut_alu();
    return bus.to_MEM_data[38:7];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  logic [31:0] ops_a, ops_b;
  int          tbl_op  [7] = '{4, 5, 6, 7, 8, 9, 10};
  logic [31:0] tbl_exp [7] = '{32'h00000004, 32'h0F0FF000, 32'hF0F00FFF, 32'hF0F00FFB,
                               32'h0F000FF0, 32'h0F0F000F, 32'hFF0F000F};
  logic [31:0] held_addr;

  initial begin
    reset = 1'b1;
    bus.ID_to_EX_valid = 1'b0;
    bus.MEM_allow_in = 1'b1;
    drv = mk(0, 0, 0, 0, -1, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    cmp_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // reset state
    chk("rst_to_mem_valid", bus.EX_to_MEM_valid, 1'b0);
    chk("rst_allow_in", bus.EX_allow_in, 1'b1);
    chk("rst_forward", bus.EX_forward, 38'd0);
    chk("rst_sram_en", bus.data_sram_en, 1'b0);
    chk("rst_sram_we", bus.data_sram_we, 4'h0);
    chk("rst_to_mem_data", bus.to_MEM_data, 71'd0);
    reset = 1'b0;

    // add.w
    send(mk(32'h1c000010, 5, 7, 0, 0, 0, 0, 0, 0, 4, 1));
    bus.ID_to_EX_valid = 1'b0;
    @(negedge clk);
    chk("add_result", dut_alu(), 32'd12);
    chk("add_forward", bus.EX_forward, {5'd4, 32'd12, 1'b0});
    chk("add_to_mem_valid", bus.EX_to_MEM_valid, 1'b1);

    // compare / shift / lu12i
    send(mk(32'h1c000014, 32'hFFFFFFFF, 1, 0, 2, 0, 0, 0, 0, 5, 1));
    @(negedge clk);
    chk("slt_result", dut_alu(), 32'd1);
    send(mk(32'h1c000018, 32'hFFFFFFFF, 1, 0, 3, 0, 0, 0, 0, 5, 1));
    @(negedge clk);
    chk("sltu_result", dut_alu(), 32'd0);
    send(mk(32'h1c00001c, 32'h80000000, 0, 4, 10, 0, 1, 0, 0, 6, 1));
    @(negedge clk);
    chk("sra_result", dut_alu(), 32'hF8000000);
    send(mk(32'h1c000020, 0, 0, 32'h12345000, 11, 0, 1, 0, 0, 7, 1));
    @(negedge clk);
    chk("lu12i_result", dut_alu(), 32'h12345000);

    // logic and shift ops on a fixed operand pair
    ops_a = 32'hF0F000FF;
    ops_b = 32'h00000F04;
    for (int k = 0; k < 7; k++) begin
      send(mk(32'h1c000100 + k * 4, ops_a, ops_b, 0, tbl_op[k], 0, 0, 0, 0, 8, 1));
      @(negedge clk);
      chk($sformatf("op%0d_result", tbl_op[k]), dut_alu(), tbl_exp[k]);
    end

    // st.w: no register write, so no forward
    send(mk(32'h1c000200, 32'h1000, 32'hDEADBEEF, 8, 0, 0, 1, 1, 0, 5, 0));
    bus.ID_to_EX_valid = 1'b0;
    @(negedge clk);
    chk("st_en", bus.data_sram_en, 1'b1);
    chk("st_we", bus.data_sram_we, 4'hF);
    chk("st_addr", bus.data_sram_addr, 32'h1008);
    chk("st_wdata", bus.data_sram_wdata, 32'hDEADBEEF);
    chk("st_fwd_dest", bus.EX_forward[37:33], 5'd0);
    @(posedge clk);
    @(negedge clk);

    // ld.w stalled by MEM for two cycles while ID already offers the next instruction
    bus.MEM_allow_in = 1'b0;
    send(mk(32'h1c000300, 32'h2000, 0, 4, 0, 0, 1, 0, 1, 3, 1));
    drv = mk(32'h1c000304, 20, 22, 0, 0, 0, 0, 0, 0, 9, 1);
    @(negedge clk);
    chk("ld_allow_in", bus.EX_allow_in, 1'b0);
    chk("ld_is_load", bus.EX_forward[0], 1'b1);
    chk("ld_addr", bus.data_sram_addr, 32'h2004);
    chk("ld_en", bus.data_sram_en, 1'b1);
    chk("ld_we", bus.data_sram_we, 4'h0);
    held_addr = bus.data_sram_addr;
    @(posedge clk);
    @(negedge clk);
    chk("ld_stall_addr", bus.data_sram_addr, held_addr);
    chk("ld_stall_pc", bus.to_MEM_data[70:39], 32'h1c000300);
    chk("ld_stall_is_load", bus.EX_forward[0], 1'b1);
    bus.MEM_allow_in = 1'b1;
    @(posedge clk);
    #1;
    bus.ID_to_EX_valid = 1'b0;
    @(negedge clk);
    chk("ld_release_is_load", bus.EX_forward[0], 1'b0);
    chk("ld_release_next", dut_alu(), 32'd42);
    chk("ld_release_pc", bus.to_MEM_data[70:39], 32'h1c000304);

    // back-to-back, including wraparound and bl
    send(mk(32'h1c000400, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0, 0, 10, 1));
    @(negedge clk);
    chk("b2b_add_wrap", dut_alu(), 32'd0);
    send(mk(32'h1c000404, 10, 3, 0, 1, 0, 0, 0, 0, 11, 1));
    @(negedge clk);
    chk("b2b_sub", dut_alu(), 32'd7);
    chk("b2b_sub_pc", bus.to_MEM_data[70:39], 32'h1c000404);
    send(mk(32'h1c000000, 0, 0, 4, 0, 1, 1, 0, 0, 1, 1));
    bus.ID_to_EX_valid = 1'b0;
    @(negedge clk);
    chk("bl_result", dut_alu(), 32'h1c000004);
    chk("bl_fwd_dest", bus.EX_forward[37:33], 5'd1);

    // reset while a load sits in EX
    send(mk(32'h1c000500, 32'h3000, 0, 0, 0, 0, 1, 0, 1, 2, 1));
    bus.ID_to_EX_valid = 1'b0;
    @(negedge clk);
    chk("midrst_is_load_before", bus.EX_forward[0], 1'b1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_to_mem_valid", bus.EX_to_MEM_valid, 1'b0);
    chk("midrst_sram_en", bus.data_sram_en, 1'b0);
    chk("midrst_forward", bus.EX_forward, 38'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
